branch_cond_unit: RTL and testbench

Consumer side of the status register: samples the 6 status flags written by ALU/decoder, evaluates a 4-bit condition code, and sequences a conditional branch. Sits between the instruction decoder (which issues branch requests) and the program counter (which it loads on a taken branch). Stalls evaluation while a status write is in flight, so a branch always sees the flags from the preceding instruction.

---
 rtl/jac_status_pkg.sv | 50 +++++
 rtl/branch_cond_unit_if.sv | 45 ++++
 rtl/cond_decode.sv | 46 ++++
 rtl/branch_cond_unit.sv | 127 ++++++++++++
 tb/tb_branch_cond_unit.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/jac_status_pkg.sv
// Shared definitions for the branch condition unit: flag positions, condition codes,
// FSM states and counter helpers.
package jac_status_pkg;

  localparam int unsigned NUM_STATUS_BITS = 6;
  localparam int unsigned ADDR_WIDTH      = 8;
  localparam int unsigned COND_WIDTH      = 4;
  localparam int unsigned CNT_WIDTH       = 16;

  // Bit positions inside the status register
  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 3;
  localparam int unsigned FLAG_I = 4;
  localparam int unsigned FLAG_U = 5;

  typedef enum logic [COND_WIDTH-1:0] {
    COND_AL = 4'd0,   // always
    COND_NV = 4'd1,   // never
    COND_EQ = 4'd2,   // Z
    COND_NE = 4'd3,   // !Z
    COND_CS = 4'd4,   // C
    COND_CC = 4'd5,   // !C
    COND_MI = 4'd6,   // N
    COND_PL = 4'd7,   // !N
    COND_VS = 4'd8,   // V
    COND_VC = 4'd9,   // !V
    COND_HI = 4'd10,  // C & !Z
    COND_LS = 4'd11,  // !C | Z
    COND_GE = 4'd12,  // N == V
    COND_LT = 4'd13,  // N != V
    COND_LE = 4'd14,  // Z | (N != V)
    COND_GT = 4'd15   // !Z & (N == V)
  } cond_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    EVAL = 3'd2,
    LOAD = 3'd3,
    DONE = 3'd4
  } br_state_e;

  // Saturating increment for the branch statistics counters
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == {CNT_WIDTH{1'b1}}) ? v : v + CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/branch_cond_unit_if.sv
// Decoder/status-register side bundle for branch_cond_unit.
// Counter ports exist only when BRANCH_STATS_EN is defined.
interface branch_cond_unit_if #(
  parameter int unsigned NumStatusBits = jac_status_pkg::NUM_STATUS_BITS,
  parameter int unsigned AddrWidth     = jac_status_pkg::ADDR_WIDTH
);

  logic [NumStatusBits-1:0]                 status;
  logic                                     stat_wr_en;
  logic                                     br_req;
  logic [jac_status_pkg::COND_WIDTH-1:0]    br_cond;
  logic [AddrWidth-1:0]                     br_target;
  logic                                     br_busy;
  logic                                     br_done;
  logic                                     br_taken;
  logic                                     pc_load;
  logic [AddrWidth-1:0]                     pc_next;
  logic                                     flush;
`ifdef BRANCH_STATS_EN
  logic [jac_status_pkg::CNT_WIDTH-1:0]     stat_taken_cnt;
  logic [jac_status_pkg::CNT_WIDTH-1:0]     stat_nottaken_cnt;
  logic                                     stats_clr;
`endif

  // Upstream side: decoder plus status register
  modport master (
    output status, stat_wr_en, br_req, br_cond, br_target,
`ifdef BRANCH_STATS_EN
    output stats_clr,
    input  stat_taken_cnt, stat_nottaken_cnt,
`endif
    input  br_busy, br_done, br_taken, pc_load, pc_next, flush
  );

  // Branch unit side
  modport slave (
    input  status, stat_wr_en, br_req, br_cond, br_target,
`ifdef BRANCH_STATS_EN
    input  stats_clr,
    output stat_taken_cnt, stat_nottaken_cnt,
`endif
    output br_busy, br_done, br_taken, pc_load, pc_next, flush
  );

endinterface

// File: rtl/cond_decode.sv
// Combinational condition-code evaluator: (status, cond) -> taken.
module cond_decode
  import jac_status_pkg::*;
#(
  parameter int unsigned NumStatusBits = NUM_STATUS_BITS
) (
  input  logic [NumStatusBits-1:0] status,
  input  logic [COND_WIDTH-1:0]    cond,
  output logic                     taken_c
);

  logic flag_c, flag_z, flag_n, flag_v;
  logic unused_status_c;

  assign flag_c = status[FLAG_C];
  assign flag_z = status[FLAG_Z];
  assign flag_n = status[FLAG_N];
  assign flag_v = status[FLAG_V];

  // I and U (and any wider bits) never take part in a branch decision
  assign unused_status_c = ^status;

  always_comb begin
    taken_c = 1'b0;
    unique case (cond_e'(cond))
      COND_AL: taken_c = 1'b1;
      COND_NV: taken_c = 1'b0;
      COND_EQ: taken_c = flag_z;
      COND_NE: taken_c = !flag_z;
      COND_CS: taken_c = flag_c;
      COND_CC: taken_c = !flag_c;
      COND_MI: taken_c = flag_n;
      COND_PL: taken_c = !flag_n;
      COND_VS: taken_c = flag_v;
      COND_VC: taken_c = !flag_v;
      COND_HI: taken_c = flag_c && !flag_z;
      COND_LS: taken_c = !flag_c || flag_z;
      COND_GE: taken_c = (flag_n == flag_v);
      COND_LT: taken_c = (flag_n != flag_v);
      COND_LE: taken_c = flag_z || (flag_n != flag_v);
      COND_GT: taken_c = !flag_z && (flag_n == flag_v);
      default: taken_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_cond_unit.sv
// Conditional branch sequencer: waits out status writes, evaluates the condition, loads the PC.
// Optional taken/not-taken counters are built when BRANCH_STATS_EN is defined.
module branch_cond_unit
  import jac_status_pkg::*;
#(
  parameter int unsigned NumStatusBits = NUM_STATUS_BITS,
  parameter int unsigned AddrWidth     = ADDR_WIDTH
) (
  input  logic              clk,
  input  logic              res,
  branch_cond_unit_if.slave bif
);

  br_state_e              state_q, state_d;
  logic [COND_WIDTH-1:0]  cond_q, cond_d;
  logic [AddrWidth-1:0]   target_q, target_d;
  logic                   taken_c;

  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   br_taken_q, br_taken_d;
  logic                   load_q, load_d;
  logic [AddrWidth-1:0]   pc_next_q, pc_next_d;

  cond_decode #(
    .NumStatusBits (NumStatusBits)
  ) u_cond_decode (
    .status  (bif.status),
    .cond    (cond_q),
    .taken_c (taken_c)
  );

  // Next state, request capture and next values of the registered outputs
  always_comb begin
    state_d    = state_q;
    cond_d     = cond_q;
    target_d   = target_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    load_d     = 1'b0;
    br_taken_d = br_taken_q;
    pc_next_d  = pc_next_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (bif.br_req) begin
          cond_d   = bif.br_cond;
          target_d = bif.br_target;
          state_d  = bif.stat_wr_en ? WAIT : EVAL;
        end else begin
          state_d  = IDLE;
        end
      end
      WAIT: begin
        if (!bif.stat_wr_en) state_d = EVAL;
      end
      EVAL: begin
        state_d = taken_c ? LOAD : DONE;
      end
      LOAD: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == WAIT) || (state_d == EVAL) || (state_d == LOAD);
    done_d = (state_d == DONE);
    load_d = (state_d == LOAD);
    if (load_d) pc_next_d = target_q;
    // DONE is only reached through LOAD when the branch was taken
    if (done_d) br_taken_d = (state_q == LOAD);
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q    <= IDLE;
      cond_q     <= '0;
      target_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      br_taken_q <= 1'b0;
      load_q     <= 1'b0;
      pc_next_q  <= '0;
    end else begin
      state_q    <= state_d;
      cond_q     <= cond_d;
      target_q   <= target_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      br_taken_q <= br_taken_d;
      load_q     <= load_d;
      pc_next_q  <= pc_next_d;
    end
  end

  assign bif.br_busy  = busy_q;
  assign bif.br_done  = done_q;
  assign bif.br_taken = br_taken_q;
  assign bif.pc_load  = load_q;
  assign bif.flush    = load_q;
  assign bif.pc_next  = pc_next_q;

`ifdef BRANCH_STATS_EN
  logic [CNT_WIDTH-1:0] taken_cnt_q;
  logic [CNT_WIDTH-1:0] nottaken_cnt_q;

  // Clear has priority over the completion being counted in the same cycle
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      taken_cnt_q    <= '0;
      nottaken_cnt_q <= '0;
    end else if (bif.stats_clr) begin
      taken_cnt_q    <= '0;
      nottaken_cnt_q <= '0;
    end else if (state_q == DONE) begin
      if (br_taken_q) taken_cnt_q    <= sat_inc(taken_cnt_q);
      else            nottaken_cnt_q <= sat_inc(nottaken_cnt_q);
    end
  end

  assign bif.stat_taken_cnt    = taken_cnt_q;
  assign bif.stat_nottaken_cnt = nottaken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed self-checking bench for branch_cond_unit (also covers BRANCH_STATS_EN when defined).
module tb_branch_cond_unit;
  import jac_status_pkg::*;

  logic clk = 1'b0;
  logic res = 1'b1;
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  branch_cond_unit_if bif ();

  branch_cond_unit dut (
    .clk (clk),
    .res (res),
    .bif (bif.slave)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk1({tag, "_busy"},  bif.br_busy, 1'b0);
    chk1({tag, "_done"},  bif.br_done, 1'b0);
    chk1({tag, "_load"},  bif.pc_load, 1'b0);
    chk1({tag, "_flush"}, bif.flush,   1'b0);
  endtask

  // One request with no status write in flight; checks the nominal 2/3 cycle latency
  task automatic run_branch(input string tag, input logic [5:0] s, input logic [3:0] c,
                            input logic [7:0] t, input logic exp_taken);
    bif.status    = s;
    bif.br_cond   = c;
    bif.br_target = t;
    bif.br_req    = 1'b1;
    @(negedge clk);
    bif.br_req = 1'b0;
    chk1({tag, "_c1_busy"}, bif.br_busy, 1'b1);
    chk1({tag, "_c1_done"}, bif.br_done, 1'b0);
    @(negedge clk);
    if (exp_taken) begin
      chk1({tag, "_c2_load"},  bif.pc_load, 1'b1);
      chk1({tag, "_c2_flush"}, bif.flush,   1'b1);
      chkv({tag, "_c2_pcnext"}, 16'(bif.pc_next), 16'(t));
      chk1({tag, "_c2_done"},  bif.br_done, 1'b0);
      @(negedge clk);
    end else begin
      chk1({tag, "_c2_load"}, bif.pc_load, 1'b0);
    end
    chk1({tag, "_done"},      bif.br_done,  1'b1);
    chk1({tag, "_taken"},     bif.br_taken, exp_taken);
    chk1({tag, "_done_busy"}, bif.br_busy,  1'b0);
    chk1({tag, "_done_load"}, bif.pc_load,  1'b0);
    @(negedge clk);
    chk1({tag, "_after_done"},  bif.br_done,  1'b0);
    chk1({tag, "_taken_hold"},  bif.br_taken, exp_taken);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bif.status     = '0;
    bif.stat_wr_en = 1'b0;
    bif.br_req     = 1'b0;
    bif.br_cond    = '0;
    bif.br_target  = '0;
`ifdef BRANCH_STATS_EN
    bif.stats_clr  = 1'b0;
`endif

    // Reset held, then released
    repeat (2) @(negedge clk);
    chk_idle("rst_held");
    chk1("rst_held_taken", bif.br_taken, 1'b0);
    chkv("rst_held_pcnext", 16'(bif.pc_next), 16'h0);
    res = 1'b0;
    @(negedge clk);
    chk_idle("rst_rel");
    chk1("rst_rel_taken", bif.br_taken, 1'b0);

    // Condition table, hand-evaluated against the flags
    run_branch("eq_taken",  6'b000010, 4'd2,  8'h3C, 1'b1);
    run_branch("eq_not",    6'b000000, 4'd2,  8'h55, 1'b0);
    run_branch("never",     6'b111111, 4'd1,  8'h44, 1'b0);
    run_branch("hi",        6'b000001, 4'd10, 8'h0A, 1'b1);
    run_branch("ls",        6'b000011, 4'd11, 8'h0B, 1'b1);
    run_branch("ge",        6'b001100, 4'd12, 8'hC0, 1'b1);
    run_branch("lt",        6'b000100, 4'd13, 8'hD0, 1'b1);
    run_branch("gt_not",    6'b001000, 4'd15, 8'hE0, 1'b0);
    run_branch("gt",        6'b000000, 4'd15, 8'hF0, 1'b1);
    run_branch("le_not",    6'b000000, 4'd14, 8'h14, 1'b0);
    run_branch("vc_not",    6'b001000, 4'd9,  8'h19, 1'b0);
    run_branch("pl_not",    6'b000100, 4'd7,  8'h17, 1'b0);

    // Two cycles of status write in flight: evaluation waits for the new carry
    bif.status     = 6'b000000;
    bif.br_cond    = 4'd4;
    bif.br_target  = 8'hA0;
    bif.br_req     = 1'b1;
    bif.stat_wr_en = 1'b1;
    @(negedge clk);
    bif.br_req = 1'b0;
    chk1("wait_c1_busy", bif.br_busy, 1'b1);
    chk1("wait_c1_done", bif.br_done, 1'b0);
    @(negedge clk);
    bif.stat_wr_en = 1'b0;
    bif.status     = 6'b000001;
    chk1("wait_c2_busy", bif.br_busy, 1'b1);
    chk1("wait_c2_load", bif.pc_load, 1'b0);
    @(negedge clk);
    chk1("wait_c3_busy", bif.br_busy, 1'b1);
    chk1("wait_c3_load", bif.pc_load, 1'b0);
    chk1("wait_c3_done", bif.br_done, 1'b0);
    @(negedge clk);
    bif.status = 6'b000000;
    chk1("wait_c4_load", bif.pc_load, 1'b1);
    chkv("wait_c4_pcnext", 16'(bif.pc_next), 16'h00A0);
    @(negedge clk);
    chk1("wait_c5_done",  bif.br_done,  1'b1);
    chk1("wait_c5_taken", bif.br_taken, 1'b1);
    @(negedge clk);
    chk_idle("wait_after");

    // Request during EVAL is dropped; request in the DONE cycle is accepted
    bif.status    = 6'b000000;
    bif.br_cond   = 4'd0;
    bif.br_target = 8'h11;
    bif.br_req    = 1'b1;
    @(negedge clk);
    chk1("b2b_c1_busy", bif.br_busy, 1'b1);
    bif.br_cond   = 4'd1;
    bif.br_target = 8'h22;
    @(negedge clk);
    bif.br_req = 1'b0;
    chk1("b2b_c2_load", bif.pc_load, 1'b1);
    chkv("b2b_c2_pcnext", 16'(bif.pc_next), 16'h0011);
    @(negedge clk);
    chk1("b2b_c3_done",  bif.br_done,  1'b1);
    chk1("b2b_c3_taken", bif.br_taken, 1'b1);
    chk1("b2b_c3_busy",  bif.br_busy,  1'b0);
    bif.br_cond   = 4'd3;
    bif.br_target = 8'h33;
    bif.br_req    = 1'b1;
    @(negedge clk);
    bif.br_req = 1'b0;
    chk1("b2b_c4_busy", bif.br_busy, 1'b1);
    chk1("b2b_c4_done", bif.br_done, 1'b0);
    @(negedge clk);
    chk1("b2b_c5_load", bif.pc_load, 1'b1);
    chkv("b2b_c5_pcnext", 16'(bif.pc_next), 16'h0033);
    @(negedge clk);
    chk1("b2b_c6_done",  bif.br_done,  1'b1);
    chk1("b2b_c6_taken", bif.br_taken, 1'b1);
    @(negedge clk);
    chk_idle("b2b_after");

    // Reset while a taken branch sits in EVAL
    bif.status    = 6'b000010;
    bif.br_cond   = 4'd2;
    bif.br_target = 8'h77;
    bif.br_req    = 1'b1;
    @(negedge clk);
    bif.br_req = 1'b0;
    chk1("rstmid_c1_busy", bif.br_busy, 1'b1);
    res = 1'b1;
    #1;
    chk_idle("rstmid_async");
    chk1("rstmid_async_taken", bif.br_taken, 1'b0);
    chkv("rstmid_async_pcnext", 16'(bif.pc_next), 16'h0);
    @(negedge clk);
    chk1("rstmid_held_load", bif.pc_load, 1'b0);
    res = 1'b0;
    @(negedge clk);
    chk_idle("rstmid_rel");
    @(negedge clk);
    chk_idle("rstmid_rel2");
    chkv("rstmid_pcnext", 16'(bif.pc_next), 16'h0);

`ifdef BRANCH_STATS_EN
    chkv("stats_rst_taken",    bif.stat_taken_cnt,    16'h0);
    chkv("stats_rst_nottaken", bif.stat_nottaken_cnt, 16'h0);
    run_branch("st_t0", 6'b000000, 4'd0, 8'h01, 1'b1);
    run_branch("st_t1", 6'b000000, 4'd0, 8'h02, 1'b1);
    run_branch("st_t2", 6'b000000, 4'd0, 8'h03, 1'b1);
    run_branch("st_n0", 6'b000000, 4'd1, 8'h04, 1'b0);
    chkv("stats_taken3",    bif.stat_taken_cnt,    16'd3);
    chkv("stats_nottaken1", bif.stat_nottaken_cnt, 16'd1);
    bif.stats_clr = 1'b1;
    @(negedge clk);
    bif.stats_clr = 1'b0;
    chkv("stats_clr_taken",    bif.stat_taken_cnt,    16'h0);
    chkv("stats_clr_nottaken", bif.stat_nottaken_cnt, 16'h0);
    // Clear coincident with the DONE cycle of a taken branch
    bif.br_cond   = 4'd0;
    bif.br_target = 8'h05;
    bif.br_req    = 1'b1;
    @(negedge clk);
    bif.br_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk1("stats_clrinc_done", bif.br_done, 1'b1);
    bif.stats_clr = 1'b1;
    @(negedge clk);
    bif.stats_clr = 1'b0;
    chkv("stats_clrinc_taken", bif.stat_taken_cnt, 16'h0);
    @(negedge clk);
    chkv("stats_clrinc_hold", bif.stat_taken_cnt, 16'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
